mem_lsu: RTL and testbench

- Multi-cycle load/store unit for the MEM stage of the MIPS pipeline. It replaces the single-cycle, zero-wait memory stage.
- Talks to data RAM over a req/ack handshake, so RAM may insert any number of wait states. Raises `stall_req_o` to the pipeline controller until the access completes.
- Supports LB/LBU/LH/LHU/LW/LWL/LWR/SB/SH/SW with big-endian byte lanes.
- Adds an access timeout with bus-error reporting.

---
 rtl/mem_lsu_if.sv | 33 +++
 rtl/mem_lsu.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_mem_lsu.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_lsu_if.sv
// Data-RAM request/acknowledge bus between the MEM-stage load/store unit (master) and data RAM.
// Byte lanes are big-endian: mem_sel_o[3] enables the byte at address offset 0.
interface mem_lsu_if #(
    parameter int unsigned ADDR_W = 32
) ();
    logic              mem_ce_o;
    logic              mem_we_o;
    logic [3:0]        mem_sel_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_data_o;
    logic [31:0]       mem_data_i;
    logic              mem_ack_i;

    modport master (
        output mem_ce_o,
        output mem_we_o,
        output mem_sel_o,
        output mem_addr_o,
        output mem_data_o,
        input  mem_data_i,
        input  mem_ack_i
    );

    modport slave (
        input  mem_ce_o,
        input  mem_we_o,
        input  mem_sel_o,
        input  mem_addr_o,
        input  mem_data_o,
        output mem_data_i,
        output mem_ack_i
    );
endinterface

// File: rtl/mem_lsu.sv
// Multi-cycle MIPS MEM-stage load/store unit: req/ack RAM access with wait states and timeout.
// Optional macro MEM_LSU_ALIGN_EXC_EN: misaligned half/word accesses raise align_exc_o instead.
module mem_lsu #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        aluop_i,
    input  logic [4:0]        wd_i,
    input  logic              wreg_i,
    input  logic [31:0]       wdata_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [31:0]       reg2_i,
    output logic [4:0]        wd_o,
    output logic              wreg_o,
    output logic [31:0]       wdata_o,
    output logic              stall_req_o,
`ifdef MEM_LSU_ALIGN_EXC_EN
    output logic              align_exc_o,
`endif
    output logic              bus_err_o,
    mem_lsu_if.master         mem_bus_io
);

    localparam logic [7:0] OpLb  = 8'b1110_0000;
    localparam logic [7:0] OpLbu = 8'b1110_0100;
    localparam logic [7:0] OpLh  = 8'b1110_0001;
    localparam logic [7:0] OpLhu = 8'b1110_0101;
    localparam logic [7:0] OpLw  = 8'b1110_0011;
    localparam logic [7:0] OpLwl = 8'b1110_0010;
    localparam logic [7:0] OpLwr = 8'b1110_0110;
    localparam logic [7:0] OpSb  = 8'b1110_1000;
    localparam logic [7:0] OpSh  = 8'b1110_1001;
    localparam logic [7:0] OpSw  = 8'b1110_1011;

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StAccess = 2'd1;
    localparam logic [1:0] StDone   = 2'd2;

    localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);

    function automatic logic is_mem(input logic [7:0] op);
        case (op)
            OpLb, OpLbu, OpLh, OpLhu, OpLw, OpLwl, OpLwr, OpSb, OpSh, OpSw: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_store(input logic [7:0] op);
        return (op == OpSb) || (op == OpSh) || (op == OpSw);
    endfunction

`ifdef MEM_LSU_ALIGN_EXC_EN
    function automatic logic is_misaligned(input logic [7:0] op, input logic [1:0] off);
        case (op)
            OpLh, OpLhu, OpSh: return off[0];
            OpLw, OpSw:        return |off;
            default:           return 1'b0;
        endcase
    endfunction
`endif

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        op_q, op_d;
    logic [4:0]        wd_q, wd_d;
    logic              wreg_q, wreg_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       reg2_q, reg2_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
`ifdef MEM_LSU_ALIGN_EXC_EN
    logic              aexc_q, aexc_d;
`endif

    logic [1:0]        off;
    logic [3:0]        lane_sel;
    logic [31:0]       st_data;
    logic              word_acc;
    logic [ADDR_W-1:0] acc_addr;
    logic [31:0]       ld_data;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic              timeout_hit;

    assign off = addr_q[1:0];

    // Lane selection and store replication; misaligned halves fall back to the aligned word
    always_comb begin
        lane_sel = 4'b1111;
        st_data  = reg2_q;
        word_acc = 1'b1;
        case (op_q)
            OpLb, OpLbu, OpSb: begin
                lane_sel = 4'b1000 >> off;
                st_data  = {4{reg2_q[7:0]}};
                word_acc = 1'b0;
            end
            OpLh, OpLhu, OpSh: begin
                lane_sel = off[1] ? 4'b0011 : 4'b1100;
                st_data  = {2{reg2_q[15:0]}};
                word_acc = off[0];
            end
            default: ;
        endcase
    end

    assign acc_addr = word_acc ? {addr_q[ADDR_W-1:2], 2'b00} : addr_q;

    always_comb begin
        unique case (off)
            2'd0: ld_byte = mem_bus_io.mem_data_i[31:24];
            2'd1: ld_byte = mem_bus_io.mem_data_i[23:16];
            2'd2: ld_byte = mem_bus_io.mem_data_i[15:8];
            2'd3: ld_byte = mem_bus_io.mem_data_i[7:0];
        endcase
    end

    assign ld_half = off[1] ? mem_bus_io.mem_data_i[15:0] : mem_bus_io.mem_data_i[31:16];

    // Big-endian load formatting; LWL/LWR merge the fetched bytes into reg2
    always_comb begin
        ld_data = 32'h0;
        case (op_q)
            OpLb:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            OpLbu: ld_data = {24'h0, ld_byte};
            OpLh:  ld_data = {{16{ld_half[15]}}, ld_half};
            OpLhu: ld_data = {16'h0, ld_half};
            OpLw:  ld_data = mem_bus_io.mem_data_i;
            OpLwl: begin
                unique case (off)
                    2'd0: ld_data = mem_bus_io.mem_data_i;
                    2'd1: ld_data = {mem_bus_io.mem_data_i[23:0], reg2_q[7:0]};
                    2'd2: ld_data = {mem_bus_io.mem_data_i[15:0], reg2_q[15:0]};
                    2'd3: ld_data = {mem_bus_io.mem_data_i[7:0], reg2_q[23:0]};
                endcase
            end
            OpLwr: begin
                unique case (off)
                    2'd0: ld_data = {reg2_q[31:8], mem_bus_io.mem_data_i[31:24]};
                    2'd1: ld_data = {reg2_q[31:16], mem_bus_io.mem_data_i[31:16]};
                    2'd2: ld_data = {reg2_q[31:24], mem_bus_io.mem_data_i[31:8]};
                    2'd3: ld_data = mem_bus_io.mem_data_i;
                endcase
            end
            default: ld_data = 32'h0;
        endcase
    end

    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TimeoutCnt);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        wd_d    = wd_q;
        wreg_d  = wreg_q;
        addr_d  = addr_q;
        reg2_d  = reg2_q;
        rdata_d = rdata_q;
        err_d   = err_q;
`ifdef MEM_LSU_ALIGN_EXC_EN
        aexc_d  = aexc_q;
`endif
        case (state_q)
            StIdle: begin
                if (is_mem(aluop_i)) begin
                    op_d    = aluop_i;
                    wd_d    = wd_i;
                    wreg_d  = wreg_i;
                    addr_d  = mem_addr_i;
                    reg2_d  = reg2_i;
                    rdata_d = 32'h0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = StAccess;
`ifdef MEM_LSU_ALIGN_EXC_EN
                    aexc_d  = is_misaligned(aluop_i, mem_addr_i[1:0]);
                    if (is_misaligned(aluop_i, mem_addr_i[1:0])) begin
                        state_d = StDone;
                    end
`endif
                end
            end
            StAccess: begin
                cnt_d = cnt_q + 1'b1;
                if (mem_bus_io.mem_ack_i) begin
                    rdata_d = ld_data;
                    state_d = StDone;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                cnt_d   = '0;
                err_d   = 1'b0;
                state_d = StIdle;
`ifdef MEM_LSU_ALIGN_EXC_EN
                aexc_d  = 1'b0;
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_q    <= 8'h0;
            wd_q    <= 5'h0;
            wreg_q  <= 1'b0;
            addr_q  <= '0;
            reg2_q  <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
`ifdef MEM_LSU_ALIGN_EXC_EN
            aexc_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            wd_q    <= wd_d;
            wreg_q  <= wreg_d;
            addr_q  <= addr_d;
            reg2_q  <= reg2_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
`ifdef MEM_LSU_ALIGN_EXC_EN
            aexc_q  <= aexc_d;
`endif
        end
    end

    // Outputs are forced low while rst is held, including the combinational passthrough
    always_comb begin
        wd_o                  = 5'h0;
        wreg_o                = 1'b0;
        wdata_o               = 32'h0;
        stall_req_o           = 1'b0;
        bus_err_o             = 1'b0;
        mem_bus_io.mem_ce_o   = 1'b0;
        mem_bus_io.mem_we_o   = 1'b0;
        mem_bus_io.mem_sel_o  = 4'b0000;
        mem_bus_io.mem_addr_o = '0;
        mem_bus_io.mem_data_o = 32'h0;
`ifdef MEM_LSU_ALIGN_EXC_EN
        align_exc_o           = 1'b0;
`endif
        if (!rst) begin
            case (state_q)
                StIdle: begin
                    wd_o    = wd_i;
                    wdata_o = wdata_i;
                    if (is_mem(aluop_i)) begin
                        stall_req_o = 1'b1;
                    end else begin
                        wreg_o = wreg_i;
                    end
                end
                StAccess: begin
                    stall_req_o           = 1'b1;
                    wd_o                  = wd_q;
                    mem_bus_io.mem_ce_o   = 1'b1;
                    mem_bus_io.mem_we_o   = is_store(op_q);
                    mem_bus_io.mem_sel_o  = lane_sel;
                    mem_bus_io.mem_addr_o = acc_addr;
                    mem_bus_io.mem_data_o = is_store(op_q) ? st_data : 32'h0;
                end
                StDone: begin
                    wd_o      = wd_q;
                    wdata_o   = rdata_q;
                    bus_err_o = err_q;
                    wreg_o    = wreg_q && !is_store(op_q) && !err_q;
`ifdef MEM_LSU_ALIGN_EXC_EN
                    align_exc_o = aexc_q;
                    if (aexc_q) begin
                        wreg_o = 1'b0;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed-vector bench for mem_lsu: passthrough, loads/stores with wait states, timeout, reset.
// Covers the MEM_LSU_ALIGN_EXC_EN build as well when that macro is defined.
module tb_mem_lsu;

    localparam int unsigned TO = 4;

    localparam logic [7:0] OP_NOP  = 8'b0000_0000;
    localparam logic [7:0] OP_ADDU = 8'b0010_0001;
    localparam logic [7:0] OP_LB   = 8'b1110_0000;
    localparam logic [7:0] OP_LBU  = 8'b1110_0100;
    localparam logic [7:0] OP_LH   = 8'b1110_0001;
    localparam logic [7:0] OP_LHU  = 8'b1110_0101;
    localparam logic [7:0] OP_LW   = 8'b1110_0011;
    localparam logic [7:0] OP_LWL  = 8'b1110_0010;
    localparam logic [7:0] OP_LWR  = 8'b1110_0110;
    localparam logic [7:0] OP_SB   = 8'b1110_1000;
    localparam logic [7:0] OP_SH   = 8'b1110_1001;
    localparam logic [7:0] OP_SW   = 8'b1110_1011;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  aluop = OP_ADDU;
    logic [4:0]  wd = 5'd3;
    logic        wreg = 1'b1;
    logic [31:0] wdata_in = 32'h1234;
    logic [31:0] addr_in = 32'h0;
    logic [31:0] reg2_in = 32'h0;
    logic [4:0]  wd_out;
    logic        wreg_out;
    logic [31:0] wdata_out;
    logic        stall;
    logic        bus_err;
`ifdef MEM_LSU_ALIGN_EXC_EN
    logic        align_exc;
`endif

    int n_vec = 0;
    int n_err = 0;

    mem_lsu_if #(.ADDR_W(32)) bus ();

    mem_lsu #(
        .ADDR_W (32),
        .TIMEOUT(TO),
        .CNT_W  (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .aluop_i    (aluop),
        .wd_i       (wd),
        .wreg_i     (wreg),
        .wdata_i    (wdata_in),
        .mem_addr_i (addr_in),
        .reg2_i     (reg2_in),
        .wd_o       (wd_out),
        .wreg_o     (wreg_out),
        .wdata_o    (wdata_out),
        .stall_req_o(stall),
`ifdef MEM_LSU_ALIGN_EXC_EN
        .align_exc_o(align_exc),
`endif
        .bus_err_o  (bus_err),
        .mem_bus_io (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // One memory op: accept cycle, ACCESS cycles answered after `waits` (-1 = never), then DONE
    task automatic mem_op(input string tag, input logic [7:0] op, input logic [31:0] addr,
                          input logic [31:0] reg2, input logic [31:0] word, input int waits,
                          input logic [3:0] e_sel, input logic e_we, input logic [31:0] e_sdata,
                          input logic e_chk_addr, input logic [31:0] e_addr,
                          input logic [31:0] e_wdata, input logic e_wreg, input logic e_err);
        int acc;
        int e_acc;
        @(negedge clk);
        aluop = op; wd = 5'd7; wreg = 1'b1; wdata_in = 32'h5A5A_0000;
        addr_in = addr; reg2_in = reg2; bus.mem_data_i = word; bus.mem_ack_i = 1'b0;
        #1;
        check_eq({tag, ":accept_stall"}, 32'(stall), 32'd1);
        check_eq({tag, ":accept_ce"}, 32'(bus.mem_ce_o), 32'd0);
        check_eq({tag, ":accept_wreg"}, 32'(wreg_out), 32'd0);
        acc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            aluop = OP_NOP; wd = 5'd0; wreg = 1'b0; wdata_in = 32'h0; addr_in = 32'h0;
            reg2_in = 32'h0;
            bus.mem_ack_i = (acc == waits);
            #1;
            if (!stall) break;
            check_eq({tag, ":ce"}, 32'(bus.mem_ce_o), 32'd1);
            check_eq({tag, ":we"}, 32'(bus.mem_we_o), 32'(e_we));
            check_eq({tag, ":sel"}, 32'(bus.mem_sel_o), 32'(e_sel));
            if (e_we) check_eq({tag, ":sdata"}, bus.mem_data_o, e_sdata);
            if (e_chk_addr) check_eq({tag, ":addr"}, bus.mem_addr_o, e_addr);
            acc++;
        end
        bus.mem_ack_i = 1'b0;
        e_acc = e_err ? int'(TO) + 1 : waits + 1;
        check_eq({tag, ":done_stall"}, 32'(stall), 32'd0);
        check_eq({tag, ":access_cycles"}, 32'(acc), 32'(e_acc));
        check_eq({tag, ":done_ce"}, 32'(bus.mem_ce_o), 32'd0);
        check_eq({tag, ":done_wd"}, 32'(wd_out), 32'd7);
        check_eq({tag, ":done_wreg"}, 32'(wreg_out), 32'(e_wreg));
        check_eq({tag, ":done_buserr"}, 32'(bus_err), 32'(e_err));
        if (!e_we && !e_err) check_eq({tag, ":wdata"}, wdata_out, e_wdata);
        @(negedge clk);
        #1;
        check_eq({tag, ":after_buserr"}, 32'(bus_err), 32'd0);
        check_eq({tag, ":after_stall"}, 32'(stall), 32'd0);
    endtask

    initial begin
        bus.mem_data_i = 32'h0;
        bus.mem_ack_i  = 1'b0;
        #12;
        check_eq("reset:wdata", wdata_out, 32'h0);
        check_eq("reset:wreg", 32'(wreg_out), 32'd0);
        check_eq("reset:stall", 32'(stall), 32'd0);
        check_eq("reset:ce", 32'(bus.mem_ce_o), 32'd0);
        check_eq("reset:buserr", 32'(bus_err), 32'd0);
`ifdef MEM_LSU_ALIGN_EXC_EN
        check_eq("reset:align_exc", 32'(align_exc), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // ADDU passthrough with a stray ack that must be ignored
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            aluop = OP_ADDU; wd = 5'd3; wreg = 1'b1; wdata_in = 32'h1234 + 32'(i);
            bus.mem_ack_i = (i == 1);
            #1;
            check_eq("addu:wdata", wdata_out, 32'h1234 + 32'(i));
            check_eq("addu:wd", 32'(wd_out), 32'd3);
            check_eq("addu:wreg", 32'(wreg_out), 32'd1);
            check_eq("addu:stall", 32'(stall), 32'd0);
            check_eq("addu:ce", 32'(bus.mem_ce_o), 32'd0);
        end
        bus.mem_ack_i = 1'b0;

        mem_op("lb", OP_LB, 32'h101, 32'h0, 32'h11F2_3344, 3,
               4'b0100, 1'b0, 32'h0, 1'b0, 32'h0, 32'hFFFF_FFF2, 1'b1, 1'b0);
        mem_op("sh", OP_SH, 32'h202, 32'hAAAA_5678, 32'h0, 0,
               4'b0011, 1'b1, 32'h5678_5678, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        mem_op("lwl", OP_LWL, 32'h301, 32'h1122_3344, 32'hA1B2_C3D4, 0,
               4'b1111, 1'b0, 32'h0, 1'b1, 32'h300, 32'hB2C3_D444, 1'b1, 1'b0);
        mem_op("lwr", OP_LWR, 32'h300, 32'h1122_3344, 32'hA1B2_C3D4, 1,
               4'b1111, 1'b0, 32'h0, 1'b1, 32'h300, 32'h1122_33A1, 1'b1, 1'b0);
        mem_op("lbu", OP_LBU, 32'h103, 32'h0, 32'h11F2_3384, 0,
               4'b0001, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0000_0084, 1'b1, 1'b0);
        mem_op("lhu", OP_LHU, 32'h102, 32'h0, 32'h11F2_8344, 0,
               4'b0011, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0000_8344, 1'b1, 1'b0);
        mem_op("lh", OP_LH, 32'h100, 32'h0, 32'h91F2_8344, 2,
               4'b1100, 1'b0, 32'h0, 1'b0, 32'h0, 32'hFFFF_91F2, 1'b1, 1'b0);
        // counter must restart from 0: ack arrives exactly at the timeout count and wins
        mem_op("ack_at_limit", OP_LW, 32'h108, 32'h0, 32'h0BAD_F00D, 4,
               4'b1111, 1'b0, 32'h0, 1'b1, 32'h108, 32'h0BAD_F00D, 1'b1, 1'b0);
        mem_op("sb", OP_SB, 32'h103, 32'h0000_00C5, 32'h0, 0,
               4'b0001, 1'b1, 32'hC5C5_C5C5, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        mem_op("sw", OP_SW, 32'h404, 32'hCAFE_F00D, 32'h0, 2,
               4'b1111, 1'b1, 32'hCAFE_F00D, 1'b1, 32'h404, 32'h0, 1'b0, 1'b0);
        mem_op("timeout", OP_LW, 32'h500, 32'h0, 32'h0, -1,
               4'b1111, 1'b0, 32'h0, 1'b1, 32'h500, 32'h0, 1'b0, 1'b1);
        mem_op("after_to", OP_LW, 32'h504, 32'h0, 32'h0102_0304, 1,
               4'b1111, 1'b0, 32'h0, 1'b1, 32'h504, 32'h0102_0304, 1'b1, 1'b0);

        // Reset in the middle of an access
        @(negedge clk);
        aluop = OP_LW; addr_in = 32'h700; wd = 5'd7; wreg = 1'b1;
        #1;
        check_eq("rst_mid:accept_stall", 32'(stall), 32'd1);
        @(negedge clk);
        aluop = OP_NOP; wreg = 1'b0;
        #1;
        check_eq("rst_mid:ce_before", 32'(bus.mem_ce_o), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("rst_mid:ce", 32'(bus.mem_ce_o), 32'd0);
        check_eq("rst_mid:stall", 32'(stall), 32'd0);
        check_eq("rst_mid:wreg", 32'(wreg_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("rst_mid:idle_stall", 32'(stall), 32'd0);
        check_eq("rst_mid:idle_ce", 32'(bus.mem_ce_o), 32'd0);
        mem_op("after_rst", OP_LW, 32'h704, 32'h0, 32'h7777_1234, 0,
               4'b1111, 1'b0, 32'h0, 1'b1, 32'h704, 32'h7777_1234, 1'b1, 1'b0);

`ifdef MEM_LSU_ALIGN_EXC_EN
        @(negedge clk);
        aluop = OP_LW; addr_in = 32'h402; wd = 5'd7; wreg = 1'b1;
        #1;
        check_eq("align:accept_stall", 32'(stall), 32'd1);
        check_eq("align:accept_ce", 32'(bus.mem_ce_o), 32'd0);
        @(negedge clk);
        aluop = OP_NOP; wreg = 1'b0;
        #1;
        check_eq("align:exc", 32'(align_exc), 32'd1);
        check_eq("align:wreg", 32'(wreg_out), 32'd0);
        check_eq("align:ce", 32'(bus.mem_ce_o), 32'd0);
        check_eq("align:stall", 32'(stall), 32'd0);
        @(negedge clk);
        #1;
        check_eq("align:exc_clear", 32'(align_exc), 32'd0);
        check_eq("align:ce_idle", 32'(bus.mem_ce_o), 32'd0);
`else
        mem_op("lw_mis", OP_LW, 32'h402, 32'h0, 32'hCAFE_1234, 0,
               4'b1111, 1'b0, 32'h0, 1'b1, 32'h400, 32'hCAFE_1234, 1'b1, 1'b0);
        mem_op("lh_mis", OP_LH, 32'h101, 32'h0, 32'h91F2_8344, 1,
               4'b1100, 1'b0, 32'h0, 1'b1, 32'h100, 32'hFFFF_91F2, 1'b1, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
